// File: rtl/wide_regfile_pkg.sv
// Shared WideWord definitions: register-file geometry plus the lane-select
// (ppp) and element-width (ww) codes that the ALU and write-back agree on.
package wide_regfile_pkg;

  localparam int RF_DEPTH = 32;
  localparam int RF_WIDTH = 128;
  localparam int RF_AW    = $clog2(RF_DEPTH);

  // Lane-select codes. Codes not listed here select no lanes.
  typedef enum logic [0:2] {
    PPP_AA = 3'b000,  // all lanes
    PPP_UU = 3'b001,  // upper half, bits [0:63]
    PPP_DD = 3'b010,  // lower half, bits [64:127]
    PPP_EE = 3'b011,  // even elements
    PPP_OO = 3'b100   // odd elements
  } ppp_e;

  // Element width codes.
  typedef enum logic [0:1] {
    W8  = 2'b00,
    W16 = 2'b01,
    W32 = 2'b10,
    W64 = 2'b11
  } ww_e;

  // True when bit position bit_idx (bit 0 = MSB) falls in an odd-numbered
  // element of the given width. Element index is bit_idx / width, so its
  // LSB is the address bit just above the in-element offset.
  function automatic logic odd_elem(input int bit_idx, input logic [0:1] ww);
    logic [31:0] v_idx;
    logic        v_odd;
    v_idx = bit_idx;
    case (ww)
      W8:      v_odd = v_idx[3];
      W16:     v_odd = v_idx[4];
      W32:     v_odd = v_idx[5];
      W64:     v_odd = v_idx[6];
      default: v_odd = v_idx[3];
    endcase
    return v_odd;
  endfunction

endpackage

// File: rtl/wide_regfile_lane_mask_dec.sv
// Combinational decode of (ppp, ww) into a per-bit write mask, bit 0 = MSB.
// Shared by the register file write-back path and the ALU.
module lane_mask_dec
  import wide_regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH
) (
  input  logic [0:2]       i_ppp,
  input  logic [0:1]       i_ww,
  output logic [0:WIDTH-1] o_mask
);

  localparam int HALF = WIDTH / 2;

  logic [0:WIDTH-1] w_odd;

  // Alternating element pattern: 1 on bits belonging to odd elements
  always_comb begin
    w_odd = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      w_odd[i] = odd_elem(i, i_ww);
    end
  end

  // Pick the mask for the requested lane selection; unknown codes write nothing
  always_comb begin
    o_mask = {WIDTH{1'b0}};
    case (i_ppp)
      PPP_AA:  o_mask = {WIDTH{1'b1}};
      PPP_UU:  o_mask = {{HALF{1'b1}}, {HALF{1'b0}}};
      PPP_DD:  o_mask = {{HALF{1'b0}}, {HALF{1'b1}}};
      PPP_EE:  o_mask = ~w_odd;
      PPP_OO:  o_mask = w_odd;
      default: o_mask = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/wide_regfile.sv
// WideWord register file: DEPTH x WIDTH storage with lane-masked write-back
// and two registered read ports feeding the ALU. A read that hits the entry
// being written on the same edge captures the merged post-write word.
module wide_regfile
  import wide_regfile_pkg::*;
#(
  parameter  int DEPTH = RF_DEPTH,
  parameter  int WIDTH = RF_WIDTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [0:WIDTH-1] reg_A,
  output logic [0:WIDTH-1] reg_B,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [0:WIDTH-1] wr_data,
  input  logic [0:2]       wr_ppp,
  input  logic [0:1]       wr_ww
);

  logic [0:WIDTH-1] r_mem [DEPTH];
  logic [0:WIDTH-1] r_reg_a;
  logic [0:WIDTH-1] r_reg_b;

  logic [0:WIDTH-1] w_mask;
  logic [0:WIDTH-1] w_wr_word;
  logic [0:WIDTH-1] w_rd_a;
  logic [0:WIDTH-1] w_rd_b;

  lane_mask_dec #(
    .WIDTH (WIDTH)
  ) u_lane_mask_dec (
    .i_ppp  (wr_ppp),
    .i_ww   (wr_ww),
    .o_mask (w_mask)
  );

  // Post-write value of the addressed entry: masked lanes from wr_data
  always_comb begin
    w_wr_word = (r_mem[wr_addr] & ~w_mask) | (wr_data & w_mask);
  end

  // Port A source: write-through when it targets the entry being written
  always_comb begin
    w_rd_a = r_mem[rd_addr_a];
    if (wr_en && (wr_addr == rd_addr_a)) begin
      w_rd_a = w_wr_word;
    end else begin
      w_rd_a = r_mem[rd_addr_a];
    end
  end

  // Port B source: write-through when it targets the entry being written
  always_comb begin
    w_rd_b = r_mem[rd_addr_b];
    if (wr_en && (wr_addr == rd_addr_b)) begin
      w_rd_b = w_wr_word;
    end else begin
      w_rd_b = r_mem[rd_addr_b];
    end
  end

  // Storage array: cleared asynchronously, lane-masked write on wr_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= w_wr_word;
    end
  end

  // Operand registers: capture on rd_en, hold during stall, clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_a <= {WIDTH{1'b0}};
      r_reg_b <= {WIDTH{1'b0}};
    end else if (rd_en) begin
      r_reg_a <= w_rd_a;
      r_reg_b <= w_rd_b;
    end
  end

  assign reg_A = r_reg_a;
  assign reg_B = r_reg_b;

endmodule

// File: tb/tb_wide_regfile.sv
// Bench for wide_regfile: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_wide_regfile;
  import wide_regfile_pkg::*;

  logic         clk;
  logic         rst;
  logic         rd_en;
  logic [4:0]   rd_addr_a;
  logic [4:0]   rd_addr_b;
  logic [0:127] reg_A;
  logic [0:127] reg_B;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [0:127] wr_data;
  logic [0:2]   wr_ppp;
  logic [0:1]   wr_ww;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [0:127] m_mem [32];
  logic [0:127] m_a;
  logic [0:127] m_b;

  wide_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .reg_A     (reg_A),
    .reg_B     (reg_B),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ppp    (wr_ppp),
    .wr_ww     (wr_ww)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mask from the lane rules: element k covers bits [k*w, k*w+w-1]
  function automatic logic [0:127] ref_mask(input logic [0:2] ppp, input logic [0:1] ww);
    logic [0:127] m;
    int w;
    int elem;
    case (ww)
      W8:      w = 8;
      W16:     w = 16;
      W32:     w = 32;
      default: w = 64;
    endcase
    for (int i = 0; i < 128; i++) begin
      elem = i / w;
      case (ppp)
        PPP_AA:  m[i] = 1'b1;
        PPP_UU:  m[i] = (i < 64);
        PPP_DD:  m[i] = (i >= 64);
        PPP_EE:  m[i] = ((elem % 2) == 0);
        PPP_OO:  m[i] = ((elem % 2) == 1);
        default: m[i] = 1'b0;
      endcase
    end
    return m;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 128'h0;
    m_a = 128'h0;
    m_b = 128'h0;
  endtask

  // One rising edge of the model: apply the write, then read the updated array
  task automatic model_update();
    logic [0:127] mk;
    if (rst) begin
      model_reset();
    end else begin
      if (wr_en) begin
        mk = ref_mask(wr_ppp, wr_ww);
        m_mem[wr_addr] = (m_mem[wr_addr] & ~mk) | (wr_data & mk);
      end
      if (rd_en) begin
        m_a = m_mem[rd_addr_a];
        m_b = m_mem[rd_addr_b];
      end
    end
  endtask

  task automatic check128(input string name, input logic [0:127] act, input logic [0:127] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then advance the model at the rising edge
  task automatic drive(input logic we, input logic [4:0] wa, input logic [0:127] wd,
                       input logic [0:2] ppp, input logic [0:1] ww,
                       input logic re, input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clk);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    wr_ppp    = ppp;
    wr_ww     = ww;
    rd_en     = re;
    rd_addr_a = ra;
    rd_addr_b = rb;
    @(posedge clk);
    model_update();
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 128'h0, PPP_AA, W8, 1'b0, 5'd0, 5'd0);
  endtask

  // Every-cycle comparison of both operand ports against the model
  always @(posedge clk) begin
    #2;
    check128("model_reg_A", reg_A, m_a);
    check128("model_reg_B", reg_B, m_b);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [0:127] v_x;
    logic [0:127] v_y;
    logic [0:127] v_z;
    v_x = {4{32'hcafef00d}};
    v_y = {4{32'h12345678}};
    v_z = {4{32'h0badc0de}};

    rst = 1'b1;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 128'h0; wr_ppp = PPP_AA; wr_ww = W8;
    rd_en = 1'b0; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    model_reset();
    idle();
    idle();
    #3;
    check128("reset_reg_A", reg_A, 128'h0);
    check128("reset_reg_B", reg_B, 128'h0);
    rst = 1'b0;

    // Full write then read on both ports
    drive(1'b1, 5'd3, 128'h0102030405060708090a0b0c0d0e0f10, PPP_AA, W8, 1'b0, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 128'h0, PPP_AA, W8, 1'b1, 5'd3, 5'd3);
    #3;
    check128("full_A", reg_A, 128'h0102030405060708090a0b0c0d0e0f10);
    check128("full_B", reg_B, 128'h0102030405060708090a0b0c0d0e0f10);

    // Upper-half write of zeros over all-ones
    drive(1'b1, 5'd5, {128{1'b1}}, PPP_AA, W8, 1'b0, 5'd0, 5'd0);
    drive(1'b1, 5'd5, 128'h0, PPP_UU, W8, 1'b0, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 128'h0, PPP_AA, W8, 1'b1, 5'd5, 5'd3);
    #3;
    check128("upper_half", reg_A, 128'h0000000000000000ffffffffffffffff);

    // Even 16-bit elements and odd 8-bit elements on zero entries
    drive(1'b1, 5'd7, {128{1'b1}}, PPP_EE, W16, 1'b0, 5'd0, 5'd0);
    drive(1'b1, 5'd8, {128{1'b1}}, PPP_OO, W8, 1'b1, 5'd7, 5'd0);
    drive(1'b0, 5'd0, 128'h0, PPP_AA, W8, 1'b1, 5'd8, 5'd7);
    #3;
    check128("odd_w8", reg_A, 128'h00ff00ff00ff00ff00ff00ff00ff00ff);
    check128("even_w16", reg_B, 128'hffff0000ffff0000ffff0000ffff0000);

    // Same-edge write-through on both ports
    drive(1'b1, 5'd9, {16{8'h11}}, PPP_AA, W8, 1'b0, 5'd0, 5'd0);
    drive(1'b1, 5'd9, {16{8'h22}}, PPP_DD, W32, 1'b1, 5'd9, 5'd9);
    #3;
    check128("bypass_A", reg_A, 128'h11111111111111112222222222222222);
    check128("bypass_B", reg_B, 128'h11111111111111112222222222222222);

    // Stall: operand held while its entry is rewritten
    drive(1'b1, 5'd10, v_x, PPP_AA, W8, 1'b0, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 128'h0, PPP_AA, W8, 1'b1, 5'd10, 5'd3);
    #3;
    check128("stall_pre", reg_A, v_x);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd10, v_y, PPP_AA, W8, 1'b0, 5'd10, 5'd10);
      #3;
      check128("stall_hold", reg_A, v_x);
    end
    drive(1'b0, 5'd0, 128'h0, PPP_AA, W8, 1'b1, 5'd10, 5'd3);
    #3;
    check128("stall_release", reg_A, v_y);

    // Undefined lane code leaves the entry unchanged
    drive(1'b1, 5'd10, v_z, 3'b110, W16, 1'b0, 5'd0, 5'd0);
    drive(1'b1, 5'd10, v_z, 3'b111, W64, 1'b1, 5'd10, 5'd10);
    #3;
    check128("bad_ppp_A", reg_A, v_y);
    check128("bad_ppp_B", reg_B, v_y);

    // Asynchronous reset between edges while stalled
    idle();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check128("async_rst_A", reg_A, 128'h0);
    check128("async_rst_B", reg_B, 128'h0);
    drive(1'b1, 5'd3, v_x, PPP_AA, W8, 1'b1, 5'd3, 5'd3);
    #3;
    check128("rst_block_A", reg_A, 128'h0);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 128'h0, PPP_AA, W8, 1'b1, 5'(i), 5'(31 - i));
      #3;
      check128("post_rst_A", reg_A, 128'h0);
    end

    // Randomized traffic, addresses concentrated to force collisions
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)),
            rand128(),
            3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
    end
    idle();
    idle();
    #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
